// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory access path: funct3 encodings,
// load/store unit state encoding and the request legality check.
package rv_mem_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_LOAD,
    LSU_RMW_RD,
    LSU_STORE,
    LSU_RESP
  } lsu_state_t;

  // True when the request must be answered with an error and no memory access.
  function automatic logic req_is_bad(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] offset);
    logic illegal;
    logic misaligned;
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (we && funct3[2]);
    misaligned = ((funct3 == F3_H || funct3 == F3_HU) && offset[0]) ||
                 ((funct3 == F3_W) && (offset != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends sub-word loads, and merges
// sub-word store data into an existing memory word.
module lsu_align
  import rv_mem_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rd_word,
  output logic [XLEN-1:0] load_data,
  input  logic [XLEN-1:0] old_word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rd_word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'b0, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'b0, half_lane};
      default: load_data = rd_word;
    endcase
  end

  // Each byte lane either takes the store data routed to it or keeps the old byte.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       hit;
      logic [7:0] src;

      assign hit = (funct3[1:0] == 2'b00) ? (offset == LANE) :
                   (funct3[1:0] == 2'b01) ? (offset[1] == LANE[1]) : 1'b1;
      assign src = (funct3[1:0] == 2'b00) ? wdata[7:0] :
                   (funct3[1:0] == 2'b01) ? wdata[8*(gi%2) +: 8] : wdata[8*gi +: 8];
      assign merged_word[8*gi +: 8] = hit ? src : old_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-only data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import rv_mem_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [XLEN-1:0] mem_a,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  lsu_state_t      state_reg, state_next;
  logic            we_reg;
  logic [2:0]      funct3_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] merge_reg;
  logic [XLEN-1:0] rsp_rdata_reg;
  logic            rsp_err_reg;

  logic            accept;
  logic            bad;
  logic [XLEN-1:0] word_addr;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_word;

  assign accept    = req_valid && (state_reg == LSU_IDLE);
  assign bad       = req_is_bad(req_we, req_funct3, req_addr[1:0]);
  assign word_addr = {addr_reg[XLEN-1:2], 2'b00};
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3      (funct3_reg),
    .offset      (addr_reg[1:0]),
    .rd_word     (mem_rd),
    .load_data   (load_data),
    .old_word    (merge_reg),
    .wdata       (wdata_reg),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= LSU_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg        <= 1'b0;
      funct3_reg    <= 3'b000;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      merge_reg     <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        we_reg        <= req_we;
        funct3_reg    <= req_funct3;
        addr_reg      <= req_addr;
        wdata_reg     <= req_wdata;
        rsp_rdata_reg <= '0;
        // An error is known at accept and goes straight to RESP.
        rsp_err_reg   <= bad;
      end
      if (state_reg == LSU_LOAD)   rsp_rdata_reg <= load_data;
      if (state_reg == LSU_RMW_RD) merge_reg     <= mem_rd;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_a      = '0;
    mem_we     = 1'b0;
    mem_wd     = '0;
    case (state_reg)
      LSU_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad)                     state_next = LSU_RESP;
          else if (!req_we)            state_next = LSU_LOAD;
          else if (req_funct3 == F3_W) state_next = LSU_STORE;
          else                         state_next = LSU_RMW_RD;
        end
      end
      LSU_LOAD: begin
        mem_a      = word_addr;
        state_next = LSU_RESP;
      end
      LSU_RMW_RD: begin
        mem_a      = word_addr;
        state_next = LSU_STORE;
      end
      LSU_STORE: begin
        mem_a      = word_addr;
        mem_we     = 1'b1;
        mem_wd     = (funct3_reg == F3_W) ? wdata_reg : merged_word;
        state_next = LSU_RESP;
      end
      LSU_RESP: begin
        rsp_valid  = 1'b1;
        state_next = LSU_IDLE;
      end
      default: state_next = LSU_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array memory model, a
// behavioural reference for expected responses and a response monitor.
module tb_load_store_unit;
  import rv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  load_store_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_a      (mem_a),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT, and the bench's own expectation of its contents.
  logic [31:0] mem [0:63]     = '{default: '0};
  logic [31:0] ref_mem [0:63] = '{default: '0};

  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          nwr;
    logic [31:0] wa;
    logic [31:0] wd;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outcome of one request against the current reference memory.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] old, v, bmask;
    int          sh;
    logic        bad;
    old     = ref_mem[addr[7:2]];
    sh      = 8 * int'(addr[1:0]);
    e.rdata = '0;
    e.err   = 1'b0;
    e.nwr   = 0;
    e.wa    = addr & ~32'd3;
    e.wd    = '0;
    e.acc   = 0;
    e.lat   = 2;
    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4) ||
          ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'd0);
    if (bad) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (!we) begin
      v = old >> sh;
      case (f3)
        3'd0:    e.rdata = {{24{v[7]}}, v[7:0]};
        3'd4:    e.rdata = {24'd0, v[7:0]};
        3'd1:    e.rdata = {{16{v[15]}}, v[15:0]};
        3'd5:    e.rdata = {16'd0, v[15:0]};
        default: e.rdata = old;
      endcase
    end else begin
      e.nwr = 1;
      if (f3 == 3'd2) begin
        e.wd = wdata;
      end else begin
        bmask = (f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
        e.wd  = (old & ~(bmask << sh)) | ((wdata & bmask) << sh);
        e.lat = 3;
      end
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge with req_valid still high.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit push, output int acc);
    exp_t e;
    int   waited;
    waited     = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, expected 1", waited);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (push) begin
      e     = model(we, f3, addr, wd);
      e.acc = acc;
      sbq.push_back(e);
      if (e.nwr != 0) ref_mem[addr[7:2]] = e.wd;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sbq.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
    check({tag, "_mem_a"},     mem_a, 32'd0);
    check({tag, "_mem_we"},    {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_wd"},    mem_wd, 32'd0);
  endtask

  // Abandon an SH in RMW_RD (stage 1) or STORE (stage 2) with an asynchronous reset.
  task automatic reset_during_sh(input int stage);
    int acc;
    issue(1'b1, F3_H, 32'h46, $urandom, 1'b0, acc);
    req_valid = 1'b0;
    if (stage == 2) begin
      @(posedge clk);
      #2;
      check("rst_store_reached", {31'd0, mem_we}, 32'd1);
    end else begin
      #2;
    end
    rst = 1'b1;
    #1;
    check_reset_outputs(stage == 2 ? "rst_in_store" : "rst_in_rmw");
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mem_unchanged", mem[17], ref_mem[17]);
  endtask

  // Response monitor: pops the scoreboard whenever rsp_valid is seen.
  int          wr_cnt = 0;
  int          rsp_n  = 0;
  logic [31:0] wr_a   = '0;
  logic [31:0] wr_d   = '0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      wr_cnt = 0;
    end else begin
      if (mem_we) begin
        wr_cnt++;
        wr_a = mem_a;
        wr_d = mem_wd;
      end
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with no request outstanding, expected 0");
        end else begin
          mon_e = sbq.pop_front();
          rsp_n++;
          $display("[TB] rsp %0d: rdata=0x%08h err=%0d lat=%0d writes=%0d (exp rdata=0x%08h err=%0d)",
                   rsp_n, rsp_rdata, rsp_err, cyc - mon_e.acc + 1, wr_cnt, mon_e.rdata, mon_e.err);
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
          check("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
          check("write_count", 32'(wr_cnt), 32'(mon_e.nwr));
          check("ready_in_resp", {31'd0, req_ready}, 32'd0);
          if (mon_e.nwr != 0) begin
            check("write_addr", wr_a, mon_e.wa);
            check("write_data", wr_d, mon_e.wd);
          end
        end
        wr_cnt = 0;
      end
    end
  end

  initial begin
    int          a0, a1;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_ad;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    // SW then LW, back to back: 3-cycle spacing.
    issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b1, a0);
    issue(1'b0, F3_W, 32'h10, 32'h0, 1'b1, a1);
    check("sw_spacing", 32'(a1 - a0), 32'd3);
    idle(3);

    // SB read-modify-write, two SBs back to back: 4-cycle spacing.
    issue(1'b1, F3_W, 32'h20, 32'h11223344, 1'b1, a0);
    issue(1'b1, F3_B, 32'h22, 32'h000000AA, 1'b1, a0);
    issue(1'b1, F3_B, 32'h21, 32'h12345655, 1'b1, a1);
    check("sb_spacing", 32'(a1 - a0), 32'd4);
    issue(1'b0, F3_W, 32'h20, 32'h0, 1'b1, a0);
    idle(2);

    // Load extension on a word with sign bits set in several lanes.
    issue(1'b1, F3_W,  32'h30, 32'h80FF7F01, 1'b1, a0);
    issue(1'b0, F3_B,  32'h33, 32'h0, 1'b1, a0);
    issue(1'b0, F3_BU, 32'h33, 32'h0, 1'b1, a0);
    issue(1'b0, F3_H,  32'h30, 32'h0, 1'b1, a0);
    issue(1'b0, F3_H,  32'h32, 32'h0, 1'b1, a0);
    issue(1'b0, F3_HU, 32'h32, 32'h0, 1'b1, a0);

    // Errors: misaligned word and halfword, illegal funct3, store with unsigned funct3.
    issue(1'b0, F3_W,   32'h31, 32'h0, 1'b1, a0);
    issue(1'b1, F3_H,   32'h33, 32'hCAFEF00D, 1'b1, a0);
    issue(1'b0, 3'b011, 32'h30, 32'h0, 1'b1, a0);
    issue(1'b1, F3_BU,  32'h30, 32'h55555555, 1'b1, a0);
    issue(1'b0, F3_W,   32'h30, 32'h0, 1'b1, a0);
    idle(2);

    // Asynchronous reset in the middle of an SH.
    issue(1'b1, F3_W, 32'h44, 32'hA5A5C3C3, 1'b1, a0);
    idle(1);
    drain();
    reset_during_sh(1);
    reset_during_sh(2);
    issue(1'b1, F3_H, 32'h46, 32'h0000BEEF, 1'b1, a0);
    issue(1'b0, F3_W, 32'h44, 32'h0, 1'b1, a0);
    idle(2);

    // Randomized mix of legal and illegal requests.
    for (int n = 0; n < 200; n++) begin
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) r_f3 = 3'($urandom_range(0, 7));
      else if (r_we)                 r_f3 = 3'($urandom_range(0, 2));
      else                           r_f3 = (($urandom_range(0, 4) < 3) ? 3'($urandom_range(0, 2))
                                                                        : 3'($urandom_range(4, 5)));
      r_ad = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) != 0) begin
        if (r_f3[1:0] == 2'b01) r_ad[0]   = 1'b0;
        if (r_f3 == F3_W)       r_ad[1:0] = 2'b00;
      end
      issue(r_we, r_f3, r_ad, $urandom, 1'b1, a0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(1);
    drain();

    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator sitting between the core's execute stage and the word-addressed data memory. Accepts one load/store request at a time and performs the access over the memory's word-only port (address, write-enable, write-data, combinational read-data). It sign/zero-extends sub-word loads and implements SB/SH as read-modify-write, because the memory has no byte enables. Returns a single-cycle response with data or an error flag.

## Interface
- XLEN, 32: data and address width; only 32 is supported.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data; low byte or halfword is used for SB/SH
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned address or illegal funct3, qualified by rsp_valid
- mem_a  out  XLEN  word-aligned address {addr[31:2],2'b00}
- mem_we  out  1  memory write enable
- mem_wd  out  XLEN  memory write data
- mem_rd  in  XLEN  memory read data, combinational from mem_a

## Operation
- States: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE: req_ready=1. Handshake fires on req_valid & req_ready. On handshake, register we, funct3, addr and wdata.
- Decode at accept:
  - illegal funct3 is 011, 110, 111, or a store with funct3[2]=1 → RESP with err.
  - misaligned is H/HU with addr[0]=1, or W with addr[1:0]≠0 → RESP with err.
  - legal load → LOAD.
  - SW → STORE.
  - SB/SH → RMW_RD.
- LOAD: drive mem_a. At the clock edge, capture the extracted lane into rsp_rdata. Byte lane is addr[1:0]; halfword lane is addr[1]. B/H sign-extend; BU/HU zero-extend. Next state is RESP.
- RMW_RD: drive mem_a. At the clock edge, capture mem_rd into the merge register. Next state is STORE.
- STORE: drive mem_a and mem_we=1.
  - mem_wd is req_wdata for SW.
  - For SB/SH, mem_wd is the merge word with only the addressed byte/halfword replaced; other bytes are preserved.
  - Next state is RESP.
- RESP: rsp_valid=1 for exactly one cycle, req_ready=0. Next state is IDLE.
- Outside LOAD/RMW_RD/STORE: mem_a=0, mem_we=0, mem_wd=0.
- mem_we is decoded purely from state, so it is never high in any state but STORE.
- rsp_rdata and rsp_err hold their value until the next RESP is loaded; they are cleared to 0 when a new request is accepted.

## Timing
- Cycle 0 is the accept edge.
- Response visible (rsp_valid high):
  - LW/LH/LB/LHU/LBU: cycle 2.
  - SW: cycle 2; memory write occurs at the edge ending cycle 1.
  - SB/SH: cycle 3; write occurs at the edge ending cycle 2.
  - Error: cycle 1; no memory access is performed.
- Maximum throughput: one request per 3 cycles (SW/loads), one per 4 cycles (SB/SH).
- Reset values:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_a=0, mem_we=0, mem_wd=0.
  - merge and request registers = 0.
- Reset mid-operation is asynchronous:
  - mem_we drops immediately; a pending STORE does not write.
  - An RMW in flight is abandoned with the memory unchanged.
  - The interrupted request produces no response.
- req_valid is ignored while req_ready=0; upstream must hold the request until handshake.
- mem_rd is sampled only at the edges ending LOAD and RMW_RD.

## Structure
- Shared package `rv_mem_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu state enum.
  - XLEN default.
- One sub-module, `lsu_align` (combinational):
  - load path: (word, offset, funct3) → extended data.
  - store path: (old word, wdata, offset, funct3) → merged word.
  - Instantiated once in the top.
- The FSM, request registers and response registers live in load_store_unit.

## Test plan
- **SW then LW:** SW addr 0x10, data 0xDEADBEEF → mem_we high in cycle 1 only, mem_a=0x10. Then LW 0x10 → rsp_rdata=0xDEADBEEF in cycle 2, rsp_err=0.
- **SB read-modify-write:** preload word 0x11223344 at 0x20. SB addr 0x22, wdata 0x000000AA → word becomes 0x11AA3344. mem_we high only in cycle 2; rsp_valid in cycle 3.
- **Load extension:** word 0x80FF7F01 at 0x30.
  - LB 0x33 → 0xFFFFFF80; LBU 0x33 → 0x00000080.
  - LH 0x30 → 0x00007F01; LH 0x32 → 0xFFFF80FF; LHU 0x32 → 0x000080FF.
- **Errors:**
  - LW 0x31 → rsp_err=1 in cycle 1, rsp_rdata=0, memory untouched.
  - SH 0x33 → rsp_err=1, no write.
  - funct3=011 → rsp_err=1.
  - store with funct3=100 → rsp_err=1.
- **Backpressure:** hold req_valid continuously with two queued requests → second accepted only when req_ready returns high after RESP. Spacing is exactly 3 cycles for SW and 4 cycles for SB.
- **Reset during SH:** assert rst during RMW_RD or STORE → mem_we=0 immediately, memory word unchanged, no rsp_valid. All outputs read reset values, and the next request completes normally.
